mem_ring_arbiter: RTL and testbench

Shares the single external memory port (Altera on-chip RAM wrapper) between the four ring-buffer engines of the dual MIL-SPI bridge: channel 0/1 × SPI→MIL and MIL→SPI rings. It performs round-robin arbitration with an optional lock for read-modify-write pointer updates. It issues at most one memory access per cycle and routes pipelined read data back to the originating requester using a tag shift register.

---
 rtl/mem_ring_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_ring_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ring_arbiter.sv
// Round-robin arbiter sharing one memory port between the ring-buffer engines.
// Supports ownership lock for read-modify-write sequences and tagged read return.
module mem_ring_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    output logic                        mem_rd,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t        state_r;
    lock_state_t        state_nxt_s;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   owner_nxt_s;
    logic [IDX_W-1:0]   last_winner_r;
    logic [IDX_W-1:0]   rr_idx_s;
    logic               rr_found_s;
    logic [IDX_W-1:0]   win_s;
    logic               grant_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic               sel_we_s;
    logic [IDX_W-1:0]   rd_idx_r;
    logic               tag_vld_r [RD_LATENCY];
    logic [IDX_W-1:0]   tag_idx_r [RD_LATENCY];
    logic [NUM_REQ-1:0] rd_valid_nxt_s;

    // Round-robin scan starting just after the last winner; nearest requester wins.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        rr_found_s = 1'b0;
        rr_idx_s   = last_winner_r;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_v      = (int'(last_winner_r) + k) % NUM_REQ;
            rr_found_s = rr_found_s | req[idx_v[IDX_W-1:0]];
            rr_idx_s   = req[idx_v[IDX_W-1:0]] ? idx_v[IDX_W-1:0] : rr_idx_s;
        end
    end

    // Lock FSM next-state and grant decision.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        grant_s     = 1'b0;
        win_s       = rr_idx_s;
        case (state_r)
            UNLOCKED: begin
                if (rr_found_s) begin
                    grant_s = 1'b1;
                    if (req_lock[rr_idx_s]) begin
                        state_nxt_s = LOCKED;
                        owner_nxt_s = rr_idx_s;
                    end else begin
                        state_nxt_s = UNLOCKED;
                    end
                end else begin
                    state_nxt_s = UNLOCKED;
                end
            end
            LOCKED: begin
                win_s = owner_r;
                if (req[owner_r]) begin
                    grant_s     = 1'b1;
                    state_nxt_s = req_lock[owner_r] ? LOCKED : UNLOCKED;
                end else if (!req_lock[owner_r]) begin
                    state_nxt_s = UNLOCKED;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = UNLOCKED;
            end
        endcase
    end

    // One-hot grant and winner operand selection.
    always_comb begin
        gnt         = '0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_we_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = grant_s & (win_s == i[IDX_W-1:0]);
            if (win_s == i[IDX_W-1:0]) begin
                sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
                sel_we_s    = req_we[i];
            end else begin
                sel_we_s    = sel_we_s;
            end
        end
    end

    // Arbitration state: lock owner and round-robin pointer.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r       <= UNLOCKED;
            owner_r       <= '0;
            last_winner_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            if (grant_s) begin
                last_winner_r <= win_s;
            end else begin
                last_winner_r <= last_winner_r;
            end
        end
    end

    // Registered memory command issue.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
            rd_idx_r  <= '0;
        end else if (grant_s) begin
            mem_addr  <= sel_addr_s;
            mem_wdata <= sel_wdata_s;
            mem_we    <= sel_we_s;
            mem_rd    <= ~sel_we_s;
            rd_idx_r  <= win_s;
        end else begin
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
        end
    end

    // Exit tag decoded into the one-hot return strobe.
    always_comb begin
        rd_valid_nxt_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_valid_nxt_s[i] = tag_vld_r[RD_LATENCY-1] & (tag_idx_r[RD_LATENCY-1] == i[IDX_W-1:0]);
        end
    end

    // Tag pipe tracks outstanding reads so data returns to its issuer in order.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_vld_r[s] <= 1'b0;
                tag_idx_r[s] <= '0;
            end
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            tag_vld_r[0] <= mem_rd;
            tag_idx_r[0] <= rd_idx_r;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_idx_r[s] <= tag_idx_r[s-1];
            end
            rd_valid <= rd_valid_nxt_s;
            if (tag_vld_r[RD_LATENCY-1]) begin
                rd_data <= mem_rdata;
            end else begin
                rd_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_ring_arbiter.sv
// Directed self-checking bench for mem_ring_arbiter with a 2-cycle read memory model.
module tb_mem_ring_arbiter;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_we = '0;
    logic [3:0]  req_lock = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic [3:0]  rd_valid;
    logic [15:0] rd_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic [15:0] pipe1;
    logic [15:0] pipe2;
    int          n_errors = 0;
    int          n_checks = 0;

    mem_ring_arbiter #(
        .NUM_REQ(4), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(2)
    ) dut (
        .clk(clk), .nRst(nRst), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case (a)
            16'h0080: mem_model = 16'hAB45;
            16'h00C0: mem_model = 16'hFFA1;
            default:  mem_model = {a[7:0] ^ 8'h5A, a[7:0]};
        endcase
    endfunction

    // Memory read pipeline: data valid two cycles after the address is presented.
    always @(posedge clk) begin
        pipe1 <= mem_model(mem_addr);
        pipe2 <= pipe1;
    end
    assign mem_rdata = pipe2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic we, input logic lk,
                           input logic [15:0] a, input logic [15:0] d);
        req[i]              = r;
        req_we[i]           = we;
        req_lock[i]         = lk;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nRst = 1'b0;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        next_cycle();
        nRst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Single read, end-to-end latency
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        #1; check("t1_gnt", 32'(gnt), 32'h1);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
        #1; check("t1_gnt_idle", 32'(gnt), 32'h0);
        check("t1_mem_rd", 32'(mem_rd), 32'h1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0040);
        check("t1_mem_we", 32'(mem_we), 32'h0);
        next_cycle();
        #1; check("t1_mem_rd_drop", 32'(mem_rd), 32'h0);
        next_cycle();
        #1; check("t1_rdv_early", 32'(rd_valid), 32'h0);
        next_cycle();
        #1; check("t1_rdv", 32'(rd_valid), 32'h1);
        check("t1_rdata", 32'(rd_data), 32'h1A40);
        next_cycle();
        #1; check("t1_rdv_drop", 32'(rd_valid), 32'h0);

        // All four writing continuously: pure rotation
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 1'b0, 16'h00C0 + 16'(i), 16'h1000 + 16'(i));
        #1; check("t2_gnt0", 32'(gnt), 32'h1);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("t2_gnt", 32'(gnt), 32'h1 << (k % 4));
            check("t2_mem_we", 32'(mem_we), 32'h1);
            check("t2_mem_rd", 32'(mem_rd), 32'h0);
            check("t2_mem_addr", 32'(mem_addr), 32'h00C0 + 32'(k - 1));
            check("t2_mem_wdata", 32'(mem_wdata), 32'h1000 + 32'(k - 1));
            next_cycle();
        end

        // Requester 1 locks for read-modify-write while others wait
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0041, 16'h0000);
        #1; check("t3_gnt_lock", 32'(gnt), 32'h2);
        next_cycle();
        set_req(1, 1'b1, 1'b1, 1'b0, 16'h0041, 16'hBEEF);
        #1; check("t3_gnt_held", 32'(gnt), 32'h2);
        check("t3_rd_issue", 32'(mem_rd), 32'h1);
        check("t3_rd_addr", 32'(mem_addr), 32'h0041);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t3_gnt2", 32'(gnt), 32'h4);
        check("t3_wr_issue", 32'(mem_we), 32'h1);
        check("t3_wr_addr", 32'(mem_addr), 32'h0041);
        check("t3_wr_data", 32'(mem_wdata), 32'hBEEF);
        next_cycle();
        set_req(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t3_gnt3", 32'(gnt), 32'h8);
        check("t3_addr2", 32'(mem_addr), 32'h00C2);
        next_cycle();
        set_req(3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t3_gnt0", 32'(gnt), 32'h1);
        check("t3_addr3", 32'(mem_addr), 32'h00C3);
        check("t3_rdv", 32'(rd_valid), 32'h2);
        check("t3_rdata", 32'(rd_data), 32'h1B41);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t3_gnt_none", 32'(gnt), 32'h0);
        check("t3_addr0", 32'(mem_addr), 32'h00C0);

        // Back-to-back reads return in order to the right requesters
        do_reset();
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000);
        set_req(3, 1'b1, 1'b0, 1'b0, 16'h00C0, 16'h0000);
        #1; check("t4_gnt2", 32'(gnt), 32'h4);
        next_cycle();
        set_req(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t4_gnt3", 32'(gnt), 32'h8);
        next_cycle();
        set_req(3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t4_rd2", 32'(mem_rd), 32'h1);
        check("t4_addr3", 32'(mem_addr), 32'h00C0);
        next_cycle();
        next_cycle();
        #1; check("t4_rdv2", 32'(rd_valid), 32'h4);
        check("t4_rdata2", 32'(rd_data), 32'hAB45);
        next_cycle();
        #1; check("t4_rdv3", 32'(rd_valid), 32'h8);
        check("t4_rdata3", 32'(rd_data), 32'hFFA1);
        next_cycle();
        #1; check("t4_rdv_drop", 32'(rd_valid), 32'h0);

        // Reset with a read in flight discards it
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        #1; check("t5_gnt", 32'(gnt), 32'h1);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t5_rd", 32'(mem_rd), 32'h1);
        next_cycle();
        nRst = 1'b0;
        #1;
        check("t5_mem_rd", 32'(mem_rd), 32'h0);
        check("t5_mem_addr", 32'(mem_addr), 32'h0);
        check("t5_rdv", 32'(rd_valid), 32'h0);
        nRst = 1'b1;
        set_req(1, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0001);
        set_req(2, 1'b1, 1'b1, 1'b0, 16'h0012, 16'h0002);
        #1; check("t5_gnt_low", 32'(gnt), 32'h2);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            #1; check("t5_no_rdv", 32'(rd_valid), 32'h0);
            set_req(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            next_cycle();
        end

        // Owner idles holding the lock; requester 0 must wait for release
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b1, 16'h0041, 16'h5555);
        #1; check("t6_gnt_lock", 32'(gnt), 32'h2);
        next_cycle();
        set_req(1, 1'b0, 1'b1, 1'b1, 16'h0041, 16'h5555);
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h7777);
        for (int k = 0; k < 3; k++) begin
            #1; check("t6_gnt_blocked", 32'(gnt), 32'h0);
            next_cycle();
        end
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t6_gnt_release", 32'(gnt), 32'h0);
        next_cycle();
        #1; check("t6_gnt0", 32'(gnt), 32'h1);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1; check("t6_wr_addr", 32'(mem_addr), 32'h0010);
        check("t6_wr_data", 32'(mem_wdata), 32'h7777);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
